// File: rtl/core_pkg.sv
// Shared types and decode helpers for the multicycle 16-bit core controller:
// FSM state encoding, opcode values (identical to the ALU select codes), field positions.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_NOT  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SRA  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_BEZ  = 4'b0110;
  localparam logic [3:0] OP_BNZ  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  function automatic logic [3:0] opcode_of(input logic [15:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  // The branch offset reuses the rd and rs2 fields as one 8-bit two's-complement value.
  function automatic logic [7:0] branch_offset(input logic [15:0] ir);
    return {ir[RD_MSB:RD_LSB], ir[RS2_MSB:RS2_LSB]};
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_NOT) || (op == OP_AND) || (op == OP_OR) ||
           (op == OP_SRA) || (op == OP_SLL) || (op == OP_XOR);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEZ) || (op == OP_BNZ);
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return (op >= 4'b1001) && (op <= 4'b1110);
  endfunction

endpackage

// File: rtl/core_ctrl_fsm.sv
// Multicycle control unit: FETCH-DECODE-EXEC-WB per instruction, drives imem handshake,
// reg-file controls and ALU select, and updates the PC from the sampled branch result.
module core_ctrl_fsm
  import core_pkg::*;
#(
  parameter int              PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [3:0]      rf_raddr_a,
  output logic [3:0]      rf_raddr_b,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic [3:0]      alu_sel,
  input  logic            alu_ovf,
  input  logic            alu_take_branch,
  output logic [PC_W-1:0] pc,
  output logic            ovf_sticky,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            ovf_sticky_q, ovf_sticky_d;
  logic            take_q, take_d;
  // Holds off the fetch request for the first cycle after reset release.
  logic            run_q, run_d;

  logic [3:0]      opcode;
  logic [PC_W-1:0] offset_ext;
  logic            fetch_hit;

  assign opcode     = opcode_of(ir_q);
  assign offset_ext = PC_W'($signed(branch_offset(ir_q)));
  assign fetch_hit  = (state_q == FETCH) && run_q && imem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (fetch_hit) state_d = DECODE;
      DECODE:  state_d = (opcode == OP_HALT) ? HALT : EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RST_PC;
      ir_q         <= '0;
      ovf_sticky_q <= 1'b0;
      take_q       <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ovf_sticky_q <= ovf_sticky_d;
      take_q       <= take_d;
      run_q        <= run_d;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    ir_d         = ir_q;
    ovf_sticky_d = ovf_sticky_q;
    take_d       = take_q;
    run_d        = 1'b1;
    if (fetch_hit) begin
      ir_d = imem_rdata;
    end
    if (state_q == EXEC) begin
      take_d = alu_take_branch;
      if ((opcode == OP_ADD) && alu_ovf) begin
        ovf_sticky_d = 1'b1;
      end
    end
    if (state_q == WB) begin
      if (is_branch(opcode) && take_q) begin
        pc_d = pc_q + PC_W'(1) + offset_ext;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end
  end

  always_comb begin
    imem_req   = (state_q == FETCH) && run_q;
    imem_addr  = pc_q;
    pc         = pc_q;
    rf_raddr_a = ir_q[RS1_MSB:RS1_LSB];
    rf_raddr_b = ir_q[RS2_MSB:RS2_LSB];
    rf_waddr   = ir_q[RD_MSB:RD_LSB];
    rf_we      = (state_q == WB) && is_alu_op(opcode);
    alu_sel    = 4'b0000;
    if (((state_q == EXEC) || (state_q == WB)) && !is_reserved(opcode)) begin
      alu_sel = opcode;
    end
    ovf_sticky = ovf_sticky_q;
    halted     = (state_q == HALT);
  end

endmodule
